// File: rtl/hpdcache_refill_beat_fifo.sv
// hpdcache_refill_beat_fifo
//
// Buffers memory read-response beats in a DEPTH-entry circular FIFO and
// presents them to the HPDcache refill handler. Each beat is tagged with its
// index within the cache line. The block also flags lines whose beat count
// disagrees with the last flag.
//
// Optional build macro: HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN
//   When defined, a beat arriving while the FIFO is empty and the refill side
//   is ready bypasses storage in the same cycle. When undefined, the FIFO has
//   a strict one-cycle push-to-pop latency and no mem_* -> refill_* path.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mem_valid_i/ready_o   memory response handshake
//   mem_data_i/id_i/error_i/last_i   beat payload
//   refill_valid_o/ready_i           refill handler handshake
//   refill_data_o/id_o/error_o/last_o head beat payload
//   refill_beat_idx_o     index of the head beat within its line
//   occupancy_o           number of stored entries
//   proto_err_o           one-cycle pulse after a pop that broke the beat count
module hpdcache_refill_beat_fifo #(
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned BEATS_PER_LINE = 4,
    localparam int unsigned IDX_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [ID_WIDTH-1:0]   mem_id_i,
    input  logic                  mem_error_i,
    input  logic                  mem_last_i,
    output logic                  refill_valid_o,
    input  logic                  refill_ready_i,
    output logic [DATA_WIDTH-1:0] refill_data_o,
    output logic [ID_WIDTH-1:0]   refill_id_o,
    output logic                  refill_error_o,
    output logic                  refill_last_o,
    output logic [IDX_W-1:0]      refill_beat_idx_o,
    output logic [OCC_W-1:0]      occupancy_o,
    output logic                  proto_err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS_PER_LINE - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [ID_WIDTH-1:0]   id_q    [DEPTH];
    logic                  error_q [DEPTH];
    logic                  last_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [IDX_W-1:0] beat_cnt_q;
    logic             proto_err_q;

    logic bypass;
    logic push;
    logic pop;
    logic pop_store;
    logic proto_viol;

    // Bypass only exists in the feedthrough build; otherwise it is tied low
    // so that no combinational path from mem_* to refill_* is created.
`ifdef HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN
    assign bypass = (occ_q == '0) && mem_valid_i && refill_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign mem_ready_o    = (occ_q != OCC_FULL);
    assign refill_valid_o = (occ_q != '0) || bypass;

    always_comb begin
        refill_data_o  = data_q[rd_ptr_q];
        refill_id_o    = id_q[rd_ptr_q];
        refill_error_o = error_q[rd_ptr_q];
        refill_last_o  = last_q[rd_ptr_q];
        if (bypass) begin
            refill_data_o  = mem_data_i;
            refill_id_o    = mem_id_i;
            refill_error_o = mem_error_i;
            refill_last_o  = mem_last_i;
        end
    end

    // A bypassed beat is delivered directly, so it neither occupies an entry
    // nor moves the read pointer; it still counts as a pop for the line
    // bookkeeping.
    assign pop       = refill_valid_o && refill_ready_i;
    assign pop_store = pop && !bypass;
    assign push      = mem_valid_i && mem_ready_o && !bypass;

    assign refill_beat_idx_o = beat_cnt_q;
    assign occupancy_o       = occ_q;
    assign proto_err_o       = proto_err_q;

    assign proto_viol = refill_last_o ? (beat_cnt_q != IDX_LAST)
                                      : (beat_cnt_q == IDX_LAST);

    // Payload storage carries no reset: contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q]  <= mem_data_i;
            id_q[wr_ptr_q]    <= mem_id_i;
            error_q[wr_ptr_q] <= mem_error_i;
            last_q[wr_ptr_q]  <= mem_last_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            beat_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_store) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop_store) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (!push && pop_store) begin
                occ_q <= occ_q - OCC_W'(1);
            end

            if (pop) begin
                if (refill_last_o || (beat_cnt_q == IDX_LAST)) begin
                    beat_cnt_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + IDX_W'(1);
                end
            end
            proto_err_q <= pop && proto_viol;
        end
    end

endmodule

// File: doc/hpdcache_refill_beat_fifo.md
Name: hpdcache_refill_beat_fifo

Overview:
Buffering stage between the memory read-response channel and the HPDcache refill handler. It accepts memory response beats and holds them in a DEPTH-entry FIFO. It presents them to the refill handler, annotated with a per-line beat index. It flags beat-count protocol violations. Depth and beat geometry are set at instantiation from the HPDcache refill FIFO depth and cache-line/word parameters.

Parameters:
DEPTH  2  FIFO entries (>=1); instantiated with PARAM_REFILL_FIFO_DEPTH
DATA_WIDTH  128  memory response beat width, bits
ID_WIDTH  4  memory transaction ID width
BEATS_PER_LINE  4  beats per cache line = CL_WORDS*WORD_WIDTH/DATA_WIDTH (power of 2, >=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
mem_valid_i  in  1  memory beat valid
mem_ready_o  out  1  beat accepted when valid&ready
mem_data_i  in  DATA_WIDTH  beat data
mem_id_i  in  ID_WIDTH  transaction ID
mem_error_i  in  1  beat carries bus error
mem_last_i  in  1  final beat of line
refill_valid_o  out  1  beat available to refill handler
refill_ready_i  in  1  refill handler consumes
refill_data_o  out  DATA_WIDTH  head beat data
refill_id_o  out  ID_WIDTH  head beat ID
refill_error_o  out  1  head beat error
refill_last_o  out  1  head beat last
refill_beat_idx_o  out  log2(BEATS_PER_LINE) (min 1)  index of head beat within line
occupancy_o  out  log2(DEPTH+1)  stored entries
proto_err_o  out  1  one-cycle pulse on beat-count violation

Behaviour:
- Reset (rst_i high, any time, including mid-line): read/write pointers = 0; occupancy_o = 0; beat counter = 0; refill_valid_o = 0; proto_err_o = 0; mem_ready_o = 1 once reset deasserts. Stored contents discarded; data outputs don't-care while refill_valid_o=0.
- Storage: circular buffer of {data,id,error,last}. Pointers wrap DEPTH-1 -> 0, including non-power-of-2 DEPTH.
- mem_ready_o = (occupancy != DEPTH). Not a function of refill_ready_i; no combinational ready path.
- Push latency: a beat accepted in cycle N is visible at the refill port in cycle N+1 at earliest.
- refill_valid_o = (occupancy != 0). Head fields are driven from the read pointer and remain stable while valid & !ready.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. A push is refused when full, even if a pop happens in the same cycle.
- Beat counter (output side): increments on each pop. It clears to 0 on a pop with last=1, and wraps at BEATS_PER_LINE. refill_beat_idx_o = counter value.
- proto_err_o pulses in the cycle after a pop if either condition held:
  - last=1 and idx != BEATS_PER_LINE-1;
  - last=0 and idx == BEATS_PER_LINE-1.
- The violating beat is still delivered unchanged. The counter still clears on last=1.
- Error beats are forwarded unchanged and do not affect the counter.
- ID interleaving is not supported: beats of one line are contiguous. The ID is not checked.

Optional Feature:
HPDCACHE_REFILL_FIFO_FEEDTHROUGH_EN
- Defined: when occupancy==0, mem_valid_i=1 and refill_ready_i=1, the beat bypasses storage combinationally.
  - refill_valid_o=1 and the refill_* fields equal the mem_* inputs in the same cycle.
  - The beat is not written and occupancy stays 0. The beat counter and proto check apply identically.
- Defined, empty but refill_ready_i=0: the beat is stored normally.
- Undefined: strict one-cycle push latency; no combinational path from mem_* to refill_*.

Test Plan:
- Fill/drain, DEPTH=2, refill_ready_i=0: push beats D0,D1.
  - mem_ready_o=0 after the 2nd push; occupancy_o=2; a 3rd beat is held off.
  - Then ready=1: D0,D1 pop in order with beat_idx 0,1.
- Full line, BEATS_PER_LINE=4, ready always 1: 4 beats, last on the 4th.
  - Outputs appear one cycle after each push; beat_idx 0,1,2,3; proto_err_o never set; counter is 0 afterwards.
- Short line: last on the 2nd beat.
  - proto_err_o pulses once, the cycle after that pop.
  - The next line starts at beat_idx 0.
- Simultaneous push/pop when full (occupancy 2): push refused, pop occurs, occupancy becomes 1.
  - Push/pop when occupancy=1 keeps occupancy at 1 across 10 cycles with data order preserved.
- Reset mid-line: assert rst_i after 2 of 4 beats are stored.
  - refill_valid_o=0, occupancy_o=0 immediately (asynchronous).
  - After release, a new line reports beat_idx starting at 0.
- Feedthrough (macro defined), empty with ready=1: data 0xA5A5 appears on refill_data_o in the same cycle and occupancy_o stays 0.
  - Macro undefined: the same stimulus appears next cycle.
